// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM with bus-timeout and illegal-opcode traps.
module mc_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit SKIP_DECODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       bus_ready,
    output logic       bus_req,
    output logic       bus_rden,
    output logic       bus_wren,
    output logic       bus_addr_select_alu_out,
    output logic       ir_wren,
    output logic       rf_wren,
    output logic       program_counter_wren,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] control_unit_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
        MEM = 3'd4, WRITEBACK = 3'd5, TRAP = 3'd6
    } state_t;
    state_t state, next_state, retire_state;
    logic [CW-1:0] cnt;
    logic [1:0] cause_next;
    logic is_r, is_i, is_load, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, legal, timeout;
    assign is_r     = opcode == 7'b0110011;
    assign is_i     = opcode == 7'b0010011;
    assign is_load  = opcode == 7'b0000011;
    assign is_s     = opcode == 7'b0100011;
    assign is_b     = opcode == 7'b1100011;
    assign is_jal   = opcode == 7'b1101111;
    assign is_jalr  = opcode == 7'b1100111;
    assign is_lui   = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;
    assign legal = is_r | is_i | is_load | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;
    assign timeout = !bus_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign retire_state = run ? FETCH : IDLE;
    assign control_unit_state = state;
    always_comb begin
        bus_req = 1'b0;
        bus_rden = 1'b0;
        bus_wren = 1'b0;
        bus_addr_select_alu_out = 1'b0;
        ir_wren = 1'b0;
        rf_wren = 1'b0;
        program_counter_wren = 1'b0;
        trap = 1'b0;
        cause_next = 2'd0;
        next_state = state;
        case (state)
            FETCH: begin
                bus_req = 1'b1;
                bus_rden = 1'b1;
                ir_wren = bus_ready;
                if (bus_ready) next_state = SKIP_DECODE ? EXECUTE : DECODE;
                else if (timeout) begin
                    next_state = TRAP;
                    cause_next = 2'd2;
                end
            end
            DECODE: begin
                next_state = legal ? EXECUTE : TRAP;
                cause_next = legal ? 2'd0 : 2'd1;
            end
            EXECUTE: begin
                if (!legal) begin
                    next_state = TRAP;
                    cause_next = 2'd1;
                end else begin
                    rf_wren = is_jal | is_jalr | is_auipc;
                    program_counter_wren = is_b | is_jal | is_jalr | is_auipc;
                    next_state = (is_b | is_jal | is_jalr | is_auipc) ? retire_state :
                                 (is_load | is_s) ? MEM : WRITEBACK;
                end
            end
            MEM: begin
                bus_req = 1'b1;
                bus_addr_select_alu_out = 1'b1;
                bus_wren = is_s;
                bus_rden = is_load;
                program_counter_wren = bus_ready & is_s;
                if (bus_ready) next_state = is_s ? retire_state : WRITEBACK;
                else if (timeout) begin
                    next_state = TRAP;
                    cause_next = 2'd3;
                end
            end
            WRITEBACK: begin
                rf_wren = is_r | is_i | is_load | is_lui;
                program_counter_wren = 1'b1;
                next_state = retire_state;
            end
            TRAP: trap = 1'b1;
            default: next_state = run ? FETCH : IDLE;
        endcase
    end
    // The wait counter restarts on every fresh entry into a bus state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            trap_cause <= 2'd0;
        end else begin
            state <= next_state;
            if ((next_state == FETCH || next_state == MEM) && next_state != state) cnt <= '0;
            else if ((state == FETCH || state == MEM) && !bus_ready) cnt <= cnt + CW'(1);
            if (next_state == TRAP && state != TRAP) trap_cause <= cause_next;
        end
    end
endmodule
